// File: rtl/tdm_mux4.sv
// Four-channel 1-bit TDM transmitter: snapshots d0..d3 per frame, holds each slot SLOT_CYCLES clocks.
// First slot appears 1 clock after en is sampled; no backpressure, frames always run to completion.
module tdm_mux4 #(
  parameter int SLOT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  output logic z,
  output logic s0,
  output logic s1,
  output logic frame,
  output logic busy
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [3:0]       snap;
  logic [1:0]       slot;
  logic [1:0]       slot_nxt;
  logic [CNT_W-1:0] cnt;

  assign slot_nxt = slot + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      snap  <= 4'b0000;
      slot  <= 2'd0;
      cnt   <= '0;
      z     <= 1'b0;
      s1    <= 1'b0;
      s0    <= 1'b0;
      frame <= 1'b0;
      busy  <= 1'b0;
    end else begin
      frame <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state     <= RUN;
            snap      <= {d3, d2, d1, d0};
            slot      <= 2'd0;
            cnt       <= '0;
            z         <= d0;
            {s1, s0}  <= 2'b00;
            frame     <= 1'b1;
            busy      <= 1'b1;
          end else begin
            z         <= 1'b0;
            {s1, s0}  <= 2'b00;
            busy      <= 1'b0;
          end
        end
        RUN: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (slot != 2'd3) begin
              // data and select move on the same edge so the far end never sees skew
              slot      <= slot_nxt;
              z         <= snap[slot_nxt];
              {s1, s0}  <= slot_nxt;
            end else if (en) begin
              snap      <= {d3, d2, d1, d0};
              slot      <= 2'd0;
              z         <= d0;
              {s1, s0}  <= 2'b00;
              frame     <= 1'b1;
            end else begin
              state     <= IDLE;
              slot      <= 2'd0;
              z         <= 1'b0;
              {s1, s0}  <= 2'b00;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_mux4.sv
// Bench for tdm_mux4: two instances (SLOT_CYCLES=2 and 1) checked against a queue of expected outputs.
module tb_tdm_mux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;
  logic [3:0] d = 4'b0000;

  logic za, s0a, s1a, fa, ba;
  logic zb, s0b, s1b, fb, bb;
  logic [3:0] y;

  always #5 clk = ~clk;

  tdm_mux4 #(.SLOT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .en(en_a),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .z(za), .s0(s0a), .s1(s1a), .frame(fa), .busy(ba)
  );

  tdm_mux4 #(.SLOT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .z(zb), .s0(s0b), .s1(s1b), .frame(fb), .busy(bb)
  );

  // Downstream 1-to-4 demultiplexer fed from dut_a's line and select pair.
  assign y = za ? (4'b0001 << {s1a, s0a}) : 4'b0000;

  typedef struct {
    int         which;
    logic       z;
    logic [1:0] s;
    logic       f;
    logic       b;
    logic [3:0] y;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic step(input logic r, input logic ea, input logic eb, input logic [3:0] dd);
    @(negedge clk);
    rst  = r;
    en_a = ea;
    en_b = eb;
    d    = dd;
  endtask

  task automatic expect_out(input int which, input logic ez, input logic [1:0] es,
                            input logic ef, input logic eb, input logic [3:0] ey, input string nm);
    exp_t e;
    e.which = which;
    e.z = ez; e.s = es; e.f = ef; e.b = eb; e.y = ey;
    e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: everything queued before an edge describes the outputs after that edge.
  initial begin
    exp_t e;
    logic [4:0] act, req;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        req = {e.z, e.s, e.f, e.b};
        if (e.which == 0) act = {za, s1a, s0a, fa, ba};
        else              act = {zb, s1b, s0b, fb, bb};
        n_total++;
        if (act === req && (e.which != 0 || y === e.y)) begin
          n_pass++;
        end else begin
          $display("FAIL %s dut%0d t=%0t: got z,s,frame,busy=%b y=%b, need %b y=%b",
                   e.nm, e.which, $time, act, y, req, e.y);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    logic [0:7] t2_z, t3_z1, t3_z2, t5_z;
    logic [3:0] p;
    logic       ez;
    logic [1:0] es;
    t2_z  = 8'b00110011;
    t3_z1 = 8'b11000000;
    t3_z2 = 8'b00000011;
    t5_z  = 8'b01100110;

    // 1. Reset held with en high and all data ones.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 4'b1111);
      expect_out(0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "reset");
      expect_out(1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "reset");
    end
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    expect_out(0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "idle_after_reset");

    // 2. Single frame, SLOT_CYCLES=2, d=1010.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i == 0), 1'b0, 4'b1010);
      es = 2'(i / 2);
      expect_out(0, t2_z[i], es, (i == 0), 1'b1, t2_z[i] ? (4'b0001 << es) : 4'b0000, "single_frame");
    end
    step(1'b0, 1'b0, 1'b0, 4'b1010);
    expect_out(0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "single_frame_end");

    // 3. Back-to-back frames; d changes mid-frame must not leak into frame 1.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, (i < 9), 1'b0, (i < 3) ? 4'b0001 : 4'b1000);
      ez = (i < 8) ? t3_z1[i] : t3_z2[i - 8];
      es = 2'((i % 8) / 2);
      expect_out(0, ez, es, (i % 8 == 0), 1'b1, ez ? (4'b0001 << es) : 4'b0000, "back_to_back");
    end
    step(1'b0, 1'b0, 1'b0, 4'b1000);
    expect_out(0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "back_to_back_end");

    // 4. Reset mid-frame, then a clean frame with d=0010.
    step(1'b0, 1'b1, 1'b0, 4'b1111); expect_out(0, 1'b1, 2'b00, 1'b1, 1'b1, 4'b0001, "pre_reset");
    step(1'b0, 1'b0, 1'b0, 4'b1111); expect_out(0, 1'b1, 2'b00, 1'b0, 1'b1, 4'b0001, "pre_reset");
    step(1'b0, 1'b0, 1'b0, 4'b1111); expect_out(0, 1'b1, 2'b01, 1'b0, 1'b1, 4'b0010, "pre_reset");
    step(1'b0, 1'b0, 1'b0, 4'b1111); expect_out(0, 1'b1, 2'b01, 1'b0, 1'b1, 4'b0010, "pre_reset");
    step(1'b1, 1'b0, 1'b0, 4'b1111); expect_out(0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "mid_reset");
    step(1'b0, 1'b0, 1'b0, 4'b1111); expect_out(0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "post_reset");
    step(1'b0, 1'b0, 1'b0, 4'b1111); expect_out(0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "post_reset");
    step(1'b0, 1'b1, 1'b0, 4'b0010); expect_out(0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0000, "restart");
    step(1'b0, 1'b0, 1'b0, 4'b0000); expect_out(0, 1'b0, 2'b00, 1'b0, 1'b1, 4'b0000, "restart");
    step(1'b0, 1'b0, 1'b0, 4'b0000); expect_out(0, 1'b1, 2'b01, 1'b0, 1'b1, 4'b0010, "restart");
    step(1'b0, 1'b0, 1'b0, 4'b0000); expect_out(0, 1'b1, 2'b01, 1'b0, 1'b1, 4'b0010, "restart");
    step(1'b0, 1'b0, 1'b0, 4'b0000); expect_out(0, 1'b0, 2'b10, 1'b0, 1'b1, 4'b0000, "restart");
    step(1'b0, 1'b0, 1'b0, 4'b0000); expect_out(0, 1'b0, 2'b10, 1'b0, 1'b1, 4'b0000, "restart");
    step(1'b0, 1'b0, 1'b0, 4'b0000); expect_out(0, 1'b0, 2'b11, 1'b0, 1'b1, 4'b0000, "restart");
    step(1'b0, 1'b0, 1'b0, 4'b0000); expect_out(0, 1'b0, 2'b11, 1'b0, 1'b1, 4'b0000, "restart");
    step(1'b0, 1'b0, 1'b0, 4'b0000); expect_out(0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "restart_end");

    // 5. SLOT_CYCLES=1, en high for two frames, d=0110.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, (i < 5), 4'b0110);
      expect_out(1, t5_z[i], 2'(i % 4), (i % 4 == 0), 1'b1, 4'b0000, "slot1_stream");
    end
    step(1'b0, 1'b0, 1'b0, 4'b0110);
    expect_out(1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "slot1_end");

    // 6. Loopback through the demultiplexer for every data pattern.
    for (int pi = 0; pi < 16; pi++) begin
      p = 4'(pi);
      for (int i = 0; i < 8; i++) begin
        step(1'b0, (i == 0), 1'b0, (i == 0) ? p : ~p);
        es = 2'(i / 2);
        ez = p[es];
        expect_out(0, ez, es, (i == 0), 1'b1, ez ? (4'b0001 << es) : 4'b0000, "loopback");
      end
      step(1'b0, 1'b0, 1'b0, 4'b0000);
      expect_out(0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, "loopback_gap");
    end

    repeat (3) @(negedge clk);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left unchecked, need 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
